// File: rtl/dsp_data_memory_pkg.sv
// Shared sizes and memory-controller state encodings for the DSP data-memory responder.
package dsp_data_memory_pkg;
  localparam int SRAM_ADDR_LEN = 8;
  localparam int REG_WORD_LEN  = 16;

  typedef enum logic {
    MEMC_SWEEP = 1'b0,
    MEMC_RUN   = 1'b1
  } memc_state_e;
endpackage

// File: rtl/dsp_sram_bank.sv
// One SRAM bank: synchronous write, asynchronous read of the current contents.
module dsp_sram_bank #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 16
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_waddr,
  input  logic [WORD_LEN-1:0] i_wdata,
  input  logic [ADDR_LEN-1:0] i_raddr,
  output logic [WORD_LEN-1:0] o_rdata
);
  logic [WORD_LEN-1:0] r_mem [2**ADDR_LEN];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dsp_data_memory.sv
// Data-memory responder: sample ring buffer in bank 1, scratch RAM in bank 2,
// occupancy/overflow/frame tracking and a zeroing sweep after reset or clear.
module dsp_data_memory
  import dsp_data_memory_pkg::*;
#(
  parameter int ADDR_LEN  = SRAM_ADDR_LEN,
  parameter int WORD_LEN  = REG_WORD_LEN,
  parameter int FRAME_LEN = 64,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] read_addr_1,
  output logic [WORD_LEN-1:0] read_data_1,
  input  logic [ADDR_LEN-1:0] read_addr_2,
  output logic [WORD_LEN-1:0] read_data_2,
  input  logic [ADDR_LEN-1:0] write_addr_2,
  input  logic [WORD_LEN-1:0] write_data,
  input  logic                write_en,
  input  logic                smp_valid,
  input  logic [WORD_LEN-1:0] smp_data,
  output logic                smp_ready,
  input  logic                rel_valid,
  input  logic [ADDR_LEN:0]   rel_len,
  input  logic                buf_clear,
  output logic [ADDR_LEN-1:0] head_ptr,
  output logic [ADDR_LEN:0]   fill_count,
  output logic                buf_full,
  output logic                overflow,
  output logic                frame_done,
  output logic                mem_busy
);
  localparam int                CW         = ADDR_LEN + 1;
  localparam logic [ADDR_LEN:0] DEPTH_C    = CW'(2**ADDR_LEN);
  localparam logic [ADDR_LEN:0] FRAME_LAST = CW'(FRAME_LEN - 1);

  memc_state_e         r_state, w_state_nxt;
  logic [ADDR_LEN-1:0] r_sweep_ptr, r_head;
  logic [ADDR_LEN:0]   r_fill, r_frame_cnt, w_rel_amt, w_fill_nxt;
  logic                r_sweep_b2, r_overflow, r_frame_done;
  logic                w_run, w_sweep1, w_sweep2, w_clear, w_xfer, w_inc, w_store;
  logic                w_we1, w_we2;
  logic [ADDR_LEN-1:0] w_waddr1, w_waddr2;
  logic [WORD_LEN-1:0] w_wdata1, w_wdata2;

  always_ff @(posedge clk)
    if (rst) r_state <= MEMC_SWEEP;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MEMC_SWEEP: if (r_sweep_ptr == '1) w_state_nxt = MEMC_RUN;
      MEMC_RUN:   if (buf_clear)         w_state_nxt = MEMC_SWEEP;
      default:                           w_state_nxt = MEMC_SWEEP;
    endcase
  end

  always_comb begin
    w_run     = (r_state == MEMC_RUN);
    mem_busy  = !w_run;
    smp_ready = w_run && (OVERWRITE || (r_fill != DEPTH_C));
    w_sweep1  = !w_run && !rst;
    w_sweep2  = w_sweep1 && r_sweep_b2;
  end

  // buf_clear outranks everything functional in the cycle it is sampled
  assign w_clear    = w_run && buf_clear && !rst;
  assign w_xfer     = smp_valid && smp_ready && !rst && !buf_clear;
  assign w_store    = w_run && write_en && !rst && !buf_clear;
  assign w_inc      = w_xfer && (r_fill != DEPTH_C);
  assign w_rel_amt  = (w_run && rel_valid && !buf_clear) ?
                      ((rel_len < r_fill) ? rel_len : r_fill) : '0;
  assign w_fill_nxt = r_fill + {{ADDR_LEN{1'b0}}, w_inc} - w_rel_amt;

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_sweep_ptr  <= '0;
      r_head       <= '0;
      r_fill       <= '0;
      r_overflow   <= 1'b0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_sweep_b2   <= rst;
    end else begin
      if (!w_run) r_sweep_ptr <= r_sweep_ptr + 1'b1;
      r_fill       <= w_fill_nxt;
      r_frame_done <= 1'b0;
      if (w_xfer) begin
        r_head <= r_head + 1'b1;
        if (!w_inc) r_overflow <= 1'b1;
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign head_ptr   = r_head;
  assign fill_count = r_fill;
  assign buf_full   = (r_fill == DEPTH_C);
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

  // sweep owns the write ports while busy; functional writers only in RUN
  assign w_we1    = w_sweep1 || w_xfer;
  assign w_waddr1 = w_sweep1 ? r_sweep_ptr : r_head;
  assign w_wdata1 = w_sweep1 ? '0 : smp_data;
  assign w_we2    = w_sweep2 || w_store;
  assign w_waddr2 = w_sweep2 ? r_sweep_ptr : write_addr_2;
  assign w_wdata2 = w_sweep2 ? '0 : write_data;

  dsp_sram_bank #(.ADDR_LEN(ADDR_LEN), .WORD_LEN(WORD_LEN)) u_bank1 (
    .clk     (clk),
    .i_we    (w_we1),
    .i_waddr (w_waddr1),
    .i_wdata (w_wdata1),
    .i_raddr (read_addr_1),
    .o_rdata (read_data_1)
  );

  dsp_sram_bank #(.ADDR_LEN(ADDR_LEN), .WORD_LEN(WORD_LEN)) u_bank2 (
    .clk     (clk),
    .i_we    (w_we2),
    .i_waddr (w_waddr2),
    .i_wdata (w_wdata2),
    .i_raddr (read_addr_2),
    .o_rdata (read_data_2)
  );
endmodule

// File: tb/tb_dsp_data_memory.sv
// Scoreboard bench: two instances (back-pressure and overwrite) share stimulus and are
// compared each cycle against an array/counter reference model.
module tb_dsp_data_memory;
  localparam int DEPTH = 256;
  localparam int FLEN  = 64;

  logic        clk = 1'b0;
  logic        rst, write_en, smp_valid, rel_valid, buf_clear;
  logic [7:0]  read_addr_1, read_addr_2, write_addr_2;
  logic [15:0] write_data, smp_data;
  logic [8:0]  rel_len;

  logic [1:0][15:0] rd1, rd2;
  logic [1:0][7:0]  hp;
  logic [1:0][8:0]  fc;
  logic [1:0]       rdy, full, ovf, fd, busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dsp_data_memory #(.ADDR_LEN(8), .WORD_LEN(16), .FRAME_LEN(FLEN), .OVERWRITE(1'b0)) u_dut_bp (
    .clk(clk), .rst(rst),
    .read_addr_1(read_addr_1), .read_data_1(rd1[0]),
    .read_addr_2(read_addr_2), .read_data_2(rd2[0]),
    .write_addr_2(write_addr_2), .write_data(write_data), .write_en(write_en),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(rdy[0]),
    .rel_valid(rel_valid), .rel_len(rel_len), .buf_clear(buf_clear),
    .head_ptr(hp[0]), .fill_count(fc[0]), .buf_full(full[0]), .overflow(ovf[0]),
    .frame_done(fd[0]), .mem_busy(busy[0])
  );

  dsp_data_memory #(.ADDR_LEN(8), .WORD_LEN(16), .FRAME_LEN(FLEN), .OVERWRITE(1'b1)) u_dut_ow (
    .clk(clk), .rst(rst),
    .read_addr_1(read_addr_1), .read_data_1(rd1[1]),
    .read_addr_2(read_addr_2), .read_data_2(rd2[1]),
    .write_addr_2(write_addr_2), .write_data(write_data), .write_en(write_en),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(rdy[1]),
    .rel_valid(rel_valid), .rel_len(rel_len), .buf_clear(buf_clear),
    .head_ptr(hp[1]), .fill_count(fc[1]), .buf_full(full[1]), .overflow(ovf[1]),
    .frame_done(fd[1]), .mem_busy(busy[1])
  );

  task automatic check(input string nm, input int inst, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          inst;
    int          fill, head;
    bit          full, ovf, fd, busy, rdy, k1, k2;
    logic [15:0] r1, r2;
  } exp_t;
  exp_t q[$];

  logic [15:0] m1 [2][DEPTH];
  logic [15:0] m2 [DEPTH];
  bit          k1 [DEPTH];
  bit          k2 [DEPTH];
  int          m_fill[2], m_head[2], m_fcnt[2];
  bit          m_ovf[2], m_fd[2];
  bit          m_busy, m_both;
  int          m_sidx;
  bit          ow[2] = '{1'b0, 1'b1};

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1; m_sidx = 0; m_both = 1;
        for (int k = 0; k < 2; k++) begin
          m_fill[k] = 0; m_head[k] = 0; m_fcnt[k] = 0; m_ovf[k] = 0; m_fd[k] = 0;
        end
      end else if (m_busy) begin
        for (int k = 0; k < 2; k++) begin
          m1[k][m_sidx] = '0;
          m_fd[k] = 0;
        end
        k1[m_sidx] = 1;
        if (m_both) begin m2[m_sidx] = '0; k2[m_sidx] = 1; end
        if (m_sidx == DEPTH - 1) m_busy = 0;
        m_sidx = (m_sidx + 1) % DEPTH;
      end else if (buf_clear) begin
        m_busy = 1; m_sidx = 0; m_both = 0;
        for (int k = 0; k < 2; k++) begin
          m_fill[k] = 0; m_head[k] = 0; m_fcnt[k] = 0; m_ovf[k] = 0; m_fd[k] = 0;
        end
      end else begin
        if (write_en) m2[write_addr_2] = write_data;
        for (int k = 0; k < 2; k++) begin
          int pre, rel;
          bit xfer;
          pre  = m_fill[k];
          xfer = smp_valid && (ow[k] || pre < DEPTH);
          rel  = rel_valid ? ((int'(rel_len) < pre) ? int'(rel_len) : pre) : 0;
          m_fd[k] = 0;
          if (xfer) begin
            if (pre == DEPTH) m_ovf[k] = 1;
            m1[k][m_head[k]] = smp_data;
            m_head[k] = (m_head[k] + 1) % DEPTH;
            m_fcnt[k]++;
            if (m_fcnt[k] == FLEN) begin m_fcnt[k] = 0; m_fd[k] = 1; end
          end
          m_fill[k] = pre + ((xfer && pre < DEPTH) ? 1 : 0) - rel;
        end
      end
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e.inst = k;
        e.fill = m_fill[k];
        e.head = m_head[k];
        e.full = (m_fill[k] == DEPTH);
        e.ovf  = m_ovf[k];
        e.fd   = m_fd[k];
        e.busy = m_busy;
        e.rdy  = !m_busy && (ow[k] || m_fill[k] < DEPTH);
        e.k1   = k1[read_addr_1];
        e.k2   = k2[read_addr_2];
        e.r1   = m1[k][read_addr_1];
        e.r2   = m2[read_addr_2];
        q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        int   i;
        e = q.pop_front();
        i = e.inst;
        check("fill_count", i, fc[i],   e.fill);
        check("head_ptr",   i, hp[i],   e.head);
        check("buf_full",   i, full[i], e.full);
        check("overflow",   i, ovf[i],  e.ovf);
        check("frame_done", i, fd[i],   e.fd);
        check("mem_busy",   i, busy[i], e.busy);
        check("smp_ready",  i, rdy[i],  e.rdy);
        if (e.k1) check("read_data_1", i, rd1[i], e.r1);
        if (e.k2) check("read_data_2", i, rd2[i], e.r2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rnd_reads();
    read_addr_1 = 8'($urandom_range(0, DEPTH - 1));
    read_addr_2 = 8'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic idle();
    write_en = 0; smp_valid = 0; rel_valid = 0; buf_clear = 0; rel_len = '0;
  endtask

  // store with a same-cycle read of the target address, which must still see the old word
  task automatic store(input logic [7:0] a, input logic [15:0] d);
    write_en = 1; write_addr_2 = a; write_data = d; read_addr_2 = a;
    #2;
    for (int k = 0; k < 2; k++) check("same_cycle_read", k, rd2[k], m2[a]);
    step();
    write_en = 0;
  endtask

  initial begin
    rst = 1; idle();
    read_addr_1 = '0; read_addr_2 = '0; write_addr_2 = '0; write_data = '0; smp_data = '0;
    repeat (3) step();
    rst = 0;

    // reset sweep: stray store, ingest, release and clear are all ignored
    for (int i = 0; i < DEPTH; i++) begin
      rnd_reads();
      smp_valid = 1; smp_data = 16'($urandom);
      rel_valid = 1; rel_len = 9'd3;
      write_en  = (i == 10); write_addr_2 = 8'h12; write_data = 16'h1234;
      buf_clear = (i == 20);
      step();
    end
    idle(); read_addr_2 = 8'h12;
    step();

    // store / load
    store(8'h12, 16'hBEEF);
    step();
    for (int i = 0; i < 30; i++) begin
      store(8'($urandom_range(0, DEPTH - 1)), 16'($urandom));
      rnd_reads();
      step();
    end
    store(8'h12, 16'hBEEF);

    // fill past DEPTH: back-pressure on dut0, overwrite on dut1
    for (int i = 0; i < DEPTH + 4; i++) begin
      smp_valid = 1; smp_data = 16'(i); rnd_reads();
      step();
    end
    idle(); read_addr_1 = 8'd3;
    step();
    rel_valid = 1; rel_len = 9'd300;
    step();
    idle();
    step();

    // clear, then frames with one release per cycle
    buf_clear = 1;
    step();
    buf_clear = 0;
    repeat (DEPTH + 2) begin rnd_reads(); step(); end
    for (int i = 0; i < 2 * FLEN; i++) begin
      smp_valid = 1; smp_data = 16'($urandom); rel_valid = 1; rel_len = 9'd1; rnd_reads();
      step();
    end
    idle(); rel_valid = 1; rel_len = 9'd300;
    step();

    // clear mid-stream at fill_count 40; bank 2 must survive
    idle();
    for (int i = 0; i < 40; i++) begin
      smp_valid = 1; smp_data = 16'($urandom); rnd_reads();
      step();
    end
    idle(); buf_clear = 1;
    step();
    buf_clear = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      read_addr_1 = 8'($urandom_range(0, DEPTH - 1));
      read_addr_2 = (i % 2 == 0) ? 8'h12 : 8'($urandom_range(0, DEPTH - 1));
      step();
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      smp_valid    = ($urandom_range(0, 9) < 7);
      smp_data     = 16'($urandom);
      rel_valid    = ($urandom_range(0, 4) == 0);
      rel_len      = 9'($urandom_range(0, 300));
      write_en     = ($urandom_range(0, 2) == 0);
      write_addr_2 = 8'($urandom_range(0, DEPTH - 1));
      write_data   = 16'($urandom);
      buf_clear    = ($urandom_range(0, 199) == 0);
      rnd_reads();
      step();
    end
    idle();
    repeat (2) step();

    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
